// File: rtl/pipe_add_pkg.sv
// Shared types and elaboration-time helpers for the segmented pipelined adder.
package pipe_add_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Number of pipeline stages: one per SEG-bit segment.
    function automatic int stages(input int n, input int seg);
        return n / seg;
    endfunction

    // The operand must split into whole segments.
    function automatic bit width_ok(input int n, input int seg);
        return (seg > 0) && (n >= seg) && ((n % seg) == 0);
    endfunction

    // Bit offset of stage k's slice in the packed de-skew vector.
    // Stage k holds the (k+1)*SEG sum bits resolved so far.
    function automatic int done_off(input int seg, input int k);
        return seg * k * (k + 1) / 2;
    endfunction

    // Bit offset of stage k's slice in the packed skew vector.
    // Stage k holds the n-(k+1)*seg operand bits not yet consumed.
    function automatic int rem_off(input int n, input int seg, input int k);
        return k * n - seg * k * (k + 1) / 2;
    endfunction

endpackage

// File: rtl/add_seg_stage.sv
// SEG-bit ripple-carry segment built from full_adder cells. Also exposes the
// carry into the segment MSB so the top segment can derive signed overflow.
module add_seg_stage #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] seg_a,
    input  logic [SEG-1:0] seg_b,
    input  logic           seg_cin,
    output logic [SEG-1:0] seg_sum,
    output logic           seg_cout,
    output logic           seg_cmsb
);

    logic [SEG:0] carry;

    assign carry[0] = seg_cin;

    for (genvar gi = 0; gi < SEG; gi++) begin : g_bit
        full_adder u_fa (
            .a  (seg_a[gi]),
            .b  (seg_b[gi]),
            .ci (carry[gi]),
            .s  (seg_sum[gi]),
            .co (carry[gi+1])
        );
    end

    assign seg_cout = carry[SEG];
    assign seg_cmsb = carry[SEG-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipe_add_sub_n.sv
// Pipelined N-bit adder/subtractor. Each stage resolves one SEG-bit segment
// using the carry registered by the previous stage, so no carry path crosses a
// segment boundary combinationally. Unconsumed operand bits ride forward in
// skew registers, resolved sum bits in de-skew registers. The whole pipe
// advances together under a single enable.
module pipe_add_sub_n
    import pipe_add_pkg::*;
#(
    parameter int N   = 32,
    parameter int SEG = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int STAGES   = stages(N, SEG);
    localparam int DESKEW_W = done_off(SEG, STAGES);
    // With a single stage nothing is skewed; the skew vector shrinks to one unused bit.
    localparam int SKEW_W   = (STAGES > 1) ? rem_off(N, SEG, STAGES) : 1;

    if (!width_ok(N, SEG)) begin : g_width_check
        $error("pipe_add_sub_n: N (%0d) must be a multiple of SEG (%0d)", N, SEG);
    end

    op_e                 op;
    logic                adv;
    logic [N-1:0]        b_eff;
    logic                cin_eff;
    logic [STAGES-1:0]   valid_reg;
    logic [STAGES-1:0]   carry_reg;
    logic [DESKEW_W-1:0] deskew_reg;
    logic [SKEW_W-1:0]   a_skew_reg;
    logic [SKEW_W-1:0]   b_skew_reg;
    logic                ovf_reg;

    // Subtraction is a + ~b + !cin; the inversion happens once, at the input.
    assign op      = op_e'(sub);
    assign b_eff   = (op == OP_SUB) ? ~b : b;
    assign cin_eff = (op == OP_SUB) ? ~cin : cin;

    // Global advance: the pipe moves unless a valid result is being held.
    assign adv      = !valid_reg[STAGES-1] || out_ready;
    assign in_ready = rst || adv;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int LO  = gi * SEG;
        localparam int REM = N - LO - SEG;

        logic [SEG-1:0] s_a;
        logic [SEG-1:0] s_b;
        logic [SEG-1:0] s_sum;
        logic           s_cin;
        logic           s_vin;
        logic           s_cout;
        logic           s_cmsb;

        if (gi == 0) begin : g_src
            assign s_a   = a[SEG-1:0];
            assign s_b   = b_eff[SEG-1:0];
            assign s_cin = cin_eff;
            assign s_vin = in_valid;

            // First de-skew slice: just this segment's sum.
            always_ff @(posedge clk) begin
                if (rst) begin
                    deskew_reg[SEG-1:0] <= '0;
                end else if (adv) begin
                    deskew_reg[SEG-1:0] <= s_sum;
                end
            end
        end else begin : g_src
            localparam int PREV_REM  = rem_off(N, SEG, gi - 1);
            localparam int PREV_DONE = done_off(SEG, gi - 1);
            localparam int THIS_DONE = done_off(SEG, gi);

            assign s_a   = a_skew_reg[PREV_REM +: SEG];
            assign s_b   = b_skew_reg[PREV_REM +: SEG];
            assign s_cin = carry_reg[gi-1];
            assign s_vin = valid_reg[gi-1];

            // Append this segment above the bits resolved by earlier stages.
            always_ff @(posedge clk) begin
                if (rst) begin
                    deskew_reg[THIS_DONE +: LO+SEG] <= '0;
                end else if (adv) begin
                    deskew_reg[THIS_DONE +: LO+SEG] <= {s_sum, deskew_reg[PREV_DONE +: LO]};
                end
            end
        end

        add_seg_stage #(
            .SEG (SEG)
        ) u_seg (
            .seg_a    (s_a),
            .seg_b    (s_b),
            .seg_cin  (s_cin),
            .seg_sum  (s_sum),
            .seg_cout (s_cout),
            .seg_cmsb (s_cmsb)
        );

        // Per-stage valid bit and registered carry toward the next segment.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_reg[gi] <= 1'b0;
                carry_reg[gi] <= 1'b0;
            end else if (adv) begin
                valid_reg[gi] <= s_vin;
                carry_reg[gi] <= s_cout;
            end
        end

        if (REM > 0) begin : g_skew
            localparam int OFF = rem_off(N, SEG, gi);

            logic [REM-1:0] rem_a;
            logic [REM-1:0] rem_b;

            if (gi == 0) begin : g_rem_src
                assign rem_a = a[N-1:SEG];
                assign rem_b = b_eff[N-1:SEG];
            end else begin : g_rem_src
                localparam int PREV = rem_off(N, SEG, gi - 1);
                assign rem_a = a_skew_reg[PREV+SEG +: REM];
                assign rem_b = b_skew_reg[PREV+SEG +: REM];
            end

            // Carry the still-unconsumed operand bits one stage forward.
            always_ff @(posedge clk) begin
                if (adv) begin
                    a_skew_reg[OFF +: REM] <= rem_a;
                    b_skew_reg[OFF +: REM] <= rem_b;
                end
            end
        end

        if (gi == STAGES - 1) begin : g_ovf
            // Signed overflow: carry into the MSB differs from carry out of it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_reg <= 1'b0;
                end else if (adv) begin
                    ovf_reg <= s_cmsb ^ s_cout;
                end
            end
        end
    end

    assign out_valid = valid_reg[STAGES-1];
    assign sum       = deskew_reg[DESKEW_W-1 -: N];
    assign cout      = carry_reg[STAGES-1];
    assign ovf       = ovf_reg;

endmodule

// File: doc/pipe_add_sub_n.md
Name: pipe_add_sub_n

Overview:
Parametrised, pipelined N-bit adder/subtractor, successor to the fixed 8-bit ripple adder.
- Splits the operand into SEG-bit segments, one ripple segment per pipeline stage, so carry chains stay short at wide N.
- Adds carry-in, subtract mode, carry-out, signed overflow and a valid/ready stream handshake.
- Feeds the partial-product accumulation path of the multiplier datapath.

Parameters:
- N, 32, operand/result width; must be an integer multiple of SEG (elaboration error otherwise).
- SEG, 8, bits resolved per pipeline stage; STAGES = N/SEG is derived, not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts the beat this cycle.
- a  input  N  operand A.
- b  input  N  operand B.
- sub  input  1  0 = add, 1 = subtract.
- cin  input  1  carry-in (add) / borrow-in (sub).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  N  result.
- cout  output  1  carry-out (add) / not-borrow (sub).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Arithmetic:
  - add: {cout,sum} = a + b + cin.
  - sub: {cout,sum} = a + ~b + !cin, i.e. a - b - cin. cout = 1 means no borrow.
  - ovf = carry into bit N-1 XOR carry out of bit N-1.
  - All arithmetic is modulo 2^N. No saturation.
- Pipeline structure:
  - STAGES register stages. Stage k resolves bits [k*SEG +: SEG] using the carry registered by stage k-1.
  - Stage 0 uses the effective carry-in: cin for add, !cin for sub.
  - Operand bits not yet consumed (a, and b already inverted when sub) travel forward in skew registers.
  - Resolved sum segments travel forward in de-skew registers.
  - ovf is computed in the final stage.
- Latency: an accepted beat appears on out_valid exactly STAGES cycles later when there is no back-pressure (4 cycles for the defaults).
- Handshake:
  - A transfer occurs on a cycle where valid && ready.
  - Global advance enable: adv = !out_valid || out_ready; in_ready = adv.
  - When adv = 0, every stage holds: data, carries and valid bits are frozen.
  - in_valid = 0 with adv = 1 inserts a bubble. Bubbles are not collapsed.
- Throughput: one beat per cycle while out_ready = 1.
- Output stability: while out_valid = 1 and out_ready = 0, sum, cout and ovf must hold stable.
- Reset:
  - All stage valid bits, out_valid, sum, cout and ovf go to 0 on the cycle after rst is sampled high.
  - in_ready = 1 while rst is high.
  - Reset mid-operation discards every in-flight beat; none emerges after rst is released.
- Boundary cases:
  - A carry can ripple across every segment (e.g. 0xFFFFFFFF + 1); each stage consumes the registered carry, with no combinational path across segments.
  - With SEG = N (STAGES = 1): 1-cycle latency, same handshake.
  - Simultaneous in_valid and out_ready on a full pipe: output retires and input is accepted in the same cycle.

Decomposition:
- Package pipe_add_pkg holds:
  - op_e enum (OP_ADD = 0, OP_SUB = 1);
  - function stages(n, seg) returning n/seg;
  - the elaboration-time check that n % seg == 0.
- Sub-module add_seg_stage: a SEG-bit ripple adder built from the existing full_adder cells. Ports: seg_a, seg_b, seg_cin, seg_sum, seg_cout, and carry-into-MSB for the top segment.
- Register and skew logic stays in pipe_add_sub_n.

Test Plan:
1. rst high 2 cycles with in_valid = 1 -> out_valid = 0, sum = 0, cout = 0, ovf = 0, in_ready = 1; no output after release.
2. add, a = 0x000000FF, b = 0x00000001, cin = 0 -> 4 cycles later sum = 0x00000100, cout = 0, ovf = 0. Then a = 0xFFFFFFFF, b = 0x00000001 -> sum = 0x00000000, cout = 1, ovf = 0.
3. add, a = 0x7FFFFFFF, b = 0x00000001 -> sum = 0x80000000, ovf = 1, cout = 0. Then cin = 1, a = 0, b = 0 -> sum = 0x00000001.
4. sub, a = 5, b = 7, cin = 0 -> sum = 0xFFFFFFFE, cout = 0. Then a = 0x80000000, b = 1 -> sum = 0x7FFFFFFF, cout = 1, ovf = 1. Then a = 10, b = 3, cin = 1 -> sum = 6, cout = 1.
5. 8 back-to-back beats with out_ready = 0 for 3 cycles mid-stream -> in_ready low for exactly those cycles, outputs held stable, all 8 results in order, none lost or duplicated; scoreboard against a reference model.
6. rst pulsed 1 cycle with 3 beats in flight -> out_valid = 0 next cycle; the next beat accepted afterwards emerges after exactly 4 cycles with the correct value.
